fadd_arbiter: RTL and testbench

Round-robin arbiter sharing one fixed-latency `fadd` pipeline between `N_REQ` requesters. It sits between the FPU issue ports and the adder. It steers one operand pair per cycle into the adder and tracks in-flight operations with a tag shift register. Results return to per-requester response FIFOs. Credit-based issue guarantees that no result is ever dropped under response backpressure.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fadd_rsp_fifo.sv | 83 ++++++++
 rtl/fadd_arbiter.sv | 126 ++++++++++++
 tb/tb_fadd_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types for the adder arbiter slice.
// Provides the float word, the in-flight tag and FLEN.
package fpu_pkg;

  localparam int FLEN     = 32;
  // Tag id field is sized for up to 16 requesters.
  localparam int TAG_ID_W = 4;

  typedef logic [FLEN-1:0] float32_t;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } fadd_tag_t;

endpackage

// File: rtl/fadd_rsp_fifo.sv
// Per-requester response FIFO, shift-register style so the head is a register.
// Ports: i_push/i_din write, i_pop reads, o_dout head, o_vld non-empty, o_cnt fill.
module fadd_rsp_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [FLEN:0] i_din,
  input  logic          i_pop,
  output logic [FLEN:0] o_dout,
  output logic          o_vld,
  output logic [CW-1:0] o_cnt
);

  logic [FLEN:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          r_vld;

  logic          w_pop;
  logic [CW-1:0] w_wr_idx;
  logic [CW-1:0] w_cnt_nxt;
  logic [FLEN:0] w_base [DEPTH];
  logic [FLEN:0] w_next [DEPTH];

  assign w_pop    = i_pop & r_vld;
  // On a pop the tail moves down one slot before the write lands.
  assign w_wr_idx = r_cnt - CW'(w_pop);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_base[k] = w_pop ? '0 : r_mem[k];
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (w_pop) begin
        w_base[k] = r_mem[k+1];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_next[k] = (i_push && w_wr_idx == CW'(k))
                ? i_din : w_base[k];
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({i_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= w_next[k];
      end
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != '0);
    end
  end

  assign o_dout = r_mem[0];
  assign o_vld  = r_vld;
  assign o_cnt  = r_cnt;

  // Credits make a push into a full FIFO impossible.
  a_no_ovr: assert property (
    @(posedge clk) disable iff (i_rst)
    !(i_push && r_cnt == CW'(DEPTH))
  );

endmodule

// File: rtl/fadd_arbiter.sv
// Round-robin sharing of one fixed-latency fadd between N_REQ requesters.
// Ports: req_* issue side, rsp_* per-requester results, fa_* adder side.
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FLEN-1:0] req_s,
  input  logic [N_REQ*FLEN-1:0] req_t,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [N_REQ*FLEN-1:0] rsp_d,
  output logic [N_REQ-1:0]      rsp_ovf,
  output logic                  fa_issue,
  output float32_t              fa_s,
  output float32_t              fa_t,
  input  float32_t              fa_d,
  input  logic                  fa_ovf
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_infl [N_REQ];
  fadd_tag_t     r_tag  [LAT];

  logic [CW-1:0]  w_cnt  [N_REQ];
  logic [FLEN:0]  w_dout [N_REQ];
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_push;
  logic           w_found;
  logic [IW-1:0]  w_gnt;
  logic           w_wb;

  // Credits: FIFO fill plus in-flight ops must stay below DEPTH.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      logic [SW-1:0] used;
      used = {1'b0, w_cnt[i]} + {1'b0, r_infl[i]};
      w_elig[i] = req_valid[i] & ~rst & (used < SW'(DEPTH));
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_gnt   = IW'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_found && (w_gnt == IW'(i));
    end
  end

  assign fa_issue = w_found;
  assign fa_s = w_found ? req_s[FLEN*int'(w_gnt) +: FLEN] : '0;
  assign fa_t = w_found ? req_t[FLEN*int'(w_gnt) +: FLEN] : '0;

  assign w_wb = r_tag[LAT-1].v;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_push[i] = w_wb && (r_tag[LAT-1].id == TAG_ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_tag[k] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        r_infl[i] <= '0;
      end
    end else begin
      if (w_found) begin
        r_ptr <= (int'(w_gnt) == N_REQ - 1)
               ? '0 : w_gnt + 1'b1;
      end
      r_tag[0] <= '{v: w_found, id: TAG_ID_W'(w_gnt)};
      for (int k = 1; k < LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      for (int i = 0; i < N_REQ; i++) begin
        unique case ({req_ready[i], w_push[i]})
          2'b10:   r_infl[i] <= r_infl[i] + 1'b1;
          2'b01:   r_infl[i] <= r_infl[i] - 1'b1;
          default: r_infl[i] <= r_infl[i];
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    fadd_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .i_rst  (rst),
      .i_push (w_push[i]),
      .i_din  ({fa_d, fa_ovf}),
      .i_pop  (rsp_ready[i]),
      .o_dout (w_dout[i]),
      .o_vld  (rsp_valid[i]),
      .o_cnt  (w_cnt[i])
    );
    assign rsp_d[FLEN*i +: FLEN] = w_dout[i][FLEN:1];
    assign rsp_ovf[i]            = w_dout[i][0];
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter with a behavioural adder.
// Directed table, multi-cycle sequences and a per-requester scoreboard.
module tb_fadd_arbiter;
  localparam int N   = 2;
  localparam int LAT = 2;
  localparam int DEP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*32-1:0] req_s, req_t;
  logic [N-1:0]  rsp_valid, rsp_ready;
  logic [N*32-1:0] rsp_d;
  logic [N-1:0]  rsp_ovf;
  logic          fa_issue;
  logic [31:0]   fa_s, fa_t, fa_d;
  logic          fa_ovf;

  int checks = 0;
  int errors = 0;

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic [32:0] apipe [LAT];

  fadd_arbiter #(.N_REQ(N), .LAT(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d), .rsp_ovf(rsp_ovf),
    .fa_issue(fa_issue), .fa_s(fa_s), .fa_t(fa_t),
    .fa_d(fa_d), .fa_ovf(fa_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] fmodel(input logic [31:0] s,
                                         input logic [31:0] t);
    if (s == 32'h3F800000 && t == 32'h40000000)
      return {32'h40400000, 1'b0};
    if (s == 32'h7F7FFFFF && t == 32'h7F7FFFFF)
      return {32'h7F800000, 1'b1};
    return {s + t, s[31] & t[31]};
  endfunction

  always @(posedge clk) begin
    apipe[0] <= fmodel(fa_s, fa_t);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign fa_d   = apipe[LAT-1][32:1];
  assign fa_ovf = apipe[LAT-1][0];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected sums queued on accept, compared on pop.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("issue_vs_accept", 64'(fa_issue),
          64'(|(req_valid & req_ready)));
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          chk("fa_s_route", 64'(fa_s), 64'(req_s[32*i +: 32]));
          if (i == 0) q0.push_back(fmodel(req_s[31:0], req_t[31:0]));
          else        q1.push_back(fmodel(req_s[63:32], req_t[63:32]));
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          logic [32:0] got, exp;
          got = {rsp_d[32*i +: 32], rsp_ovf[i]};
          if (i == 0 && q0.size() > 0)      exp = q0.pop_front();
          else if (i == 1 && q1.size() > 0) exp = q1.pop_front();
          else                              exp = 'x;
          chk(i == 0 ? "sb_rsp0" : "sb_rsp1", 64'(got), 64'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [31:0] s, t, d;
    logic        ovf;
  } vec_t;

  vec_t tv [5];
  int a0, a1;

  initial begin
    tv[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
    tv[1] = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
    tv[2] = '{0, 32'h80000001, 32'h80000002, 32'h00000003, 1'b1};
    tv[3] = '{1, 32'h00001234, 32'h00004321, 32'h00005555, 1'b0};
    tv[4] = '{0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};

    rst = 1'b1;
    req_valid = 2'b11;
    req_s = {32'h11111111, 32'h22222222};
    req_t = {32'h33333333, 32'h44444444};
    rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_fa_issue", 64'(fa_issue), 64'd0);
    chk("rst_fa_s", 64'(fa_s), 64'd0);
    chk("rst_fa_t", 64'(fa_t), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_d", 64'(rsp_d), 64'd0);
    chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    req_valid = '0;
    rsp_ready = '0;
    tick();
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      int id;
      id = tv[v].id;
      req_valid = 2'(1 << id);
      req_s[32*id +: 32] = tv[v].s;
      req_t[32*id +: 32] = tv[v].t;
      @(negedge clk);
      chk("tv_ready", 64'(req_ready), 64'(1 << id));
      chk("tv_fa_s", 64'(fa_s), 64'(tv[v].s));
      chk("tv_fa_t", 64'(fa_t), 64'(tv[v].t));
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      chk("tv_early_rsp", 64'(rsp_valid[id]), 64'd0);
      tick();
      rsp_ready = 2'(1 << id);
      @(negedge clk);
      chk("tv_rsp_valid", 64'(rsp_valid[id]), 64'd1);
      chk("tv_rsp_d", 64'(rsp_d[32*id +: 32]), 64'(tv[v].d));
      chk("tv_rsp_ovf", 64'(rsp_ovf[id]), 64'(tv[v].ovf));
      tick();
      rsp_ready = '0;
    end

    // Push and pop on one FIFO holding a single entry.
    do_reset();
    rsp_ready = '0;
    req_valid = 2'b01;
    req_s[31:0] = 32'h00000100;
    req_t[31:0] = 32'h00000023;
    @(negedge clk);
    chk("sc_acc_a", 64'(req_ready), 64'd1);
    tick();
    req_s[31:0] = 32'h00000200;
    req_t[31:0] = 32'h00000045;
    @(negedge clk);
    chk("sc_acc_b", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    tick();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("sc_head_a", 64'(rsp_d[31:0]), 64'h123);
    tick();
    @(negedge clk);
    chk("sc_valid_b", 64'(rsp_valid[0]), 64'd1);
    chk("sc_head_b", 64'(rsp_d[31:0]), 64'h245);
    tick();
    rsp_ready = '0;
    @(negedge clk);
    chk("sc_empty", 64'(rsp_valid[0]), 64'd0);

    // Accept and writeback for the same requester in one cycle.
    do_reset();
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("infl_one", 64'(dut.r_infl[0]), 64'd1);
    tick();
    req_valid = 2'b01;
    @(negedge clk);
    chk("infl_acc_wb", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("infl_same", 64'(dut.r_infl[0]), 64'd1);
    repeat (LAT + 3) tick();

    // Contention: grants alternate starting from requester 0.
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      req_s = {$urandom, $urandom};
      req_t = {$urandom, $urandom};
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    req_valid = '0;
    repeat (LAT + 3) tick();
    chk("rr_drain0", 64'(q0.size()), 64'd0);
    chk("rr_drain1", 64'(q1.size()), 64'd0);

    // Backpressure on requester 1.
    do_reset();
    rsp_ready = 2'b01;
    a0 = 0;
    a1 = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid = 2'b11;
      req_s = {$urandom, $urandom};
      req_t = {$urandom, $urandom};
      @(negedge clk);
      if (req_ready[1]) a1++;
      if (req_ready[0] && k >= 6) a0++;
      tick();
    end
    chk("bp_req1_count", 64'(a1), 64'd2);
    chk("bp_req0_moves", 64'(a0 >= 2), 64'd1);
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_pop_cycle", 64'(req_ready[1]), 64'd0);
    tick();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_next_cycle", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (LAT + 5) tick();
    chk("bp_drain0", 64'(q0.size()), 64'd0);
    chk("bp_drain1", 64'(q1.size()), 64'd0);

    // Reset with two operations in flight.
    do_reset();
    rsp_ready = '0;
    req_valid = 2'b01;
    req_s = {32'h00000007, 32'h00000005};
    req_t = {32'h00000009, 32'h00000003};
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_infl0", 64'(dut.r_infl[0]), 64'd0);
    chk("mr_infl1", 64'(dut.r_infl[1]), 64'd0);
    chk("mr_cnt0", 64'(dut.w_cnt[0]), 64'd0);
    chk("mr_cnt1", 64'(dut.w_cnt[1]), 64'd0);
    for (int k = 0; k < 2 * LAT; k++) begin
      tick();
      @(negedge clk);
      chk("mr_quiet", 64'(rsp_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
